// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared opcodes, controller state encoding and strobe decode for the nn block
//
// Shared by nn_layer_ctrl, nn_loop_cnt and alu. No ports.
//   OP_*      : ALU opcodes (alu decodes the same values)
//   ST_*      : nn_layer_ctrl FSM state encoding
//   strobe_t  : per-state memory/aggregator strobes
//   decode_strobes : state -> strobes, kept here so the encoding and its
//                    meaning live in one place
package nn_pkg;

  localparam int OPCODE_W = 2;
  localparam int STATE_W  = 3;

  localparam logic [OPCODE_W-1:0] OP_NOP = 2'd0;
  localparam logic [OPCODE_W-1:0] OP_MUL = 2'd1;
  localparam logic [OPCODE_W-1:0] OP_ADD = 2'd2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_CLEAR = 3'd1;
  localparam logic [STATE_W-1:0] ST_READ  = 3'd2;
  localparam logic [STATE_W-1:0] ST_DRAIN = 3'd3;
  localparam logic [STATE_W-1:0] ST_WRITE = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

  typedef struct packed {
    logic rd;    // input + weight memory read
    logic clr;   // aggregator clear
    logic we;    // output memory write
    logic dn;    // job-complete pulse
    logic busy;  // anything but IDLE
  } strobe_t;

  // Strobes are pure functions of the state register, so none of them has a
  // combinational path from the block inputs.
  function automatic strobe_t decode_strobes(input logic [STATE_W-1:0] st);
    strobe_t s;
    s      = '0;
    s.rd   = (st == ST_READ);
    s.clr  = (st == ST_CLEAR);
    s.we   = (st == ST_WRITE);
    s.dn   = (st == ST_DONE);
    s.busy = (st != ST_IDLE);
    return s;
  endfunction

endpackage

// File: rtl/nn_loop_cnt.sv
// rtl/nn_loop_cnt.sv - loop index counter with clear, increment and terminal-count flag
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : force the count to 0 (wins over inc)
//   inc      : advance the count by one
//   limit    : loop trip count; last is meaningful only for limit != 0
//   cnt      : current index
//   last     : cnt is the final index (limit-1)
module nn_loop_cnt
  import nn_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  // Comparing against limit-1 instead of limit means the counter only ever
  // reaches limit itself on the final increment, so a 2^W-1 trip count never
  // wraps.
  assign last = (cnt == (limit - W'(1)));

endmodule

// File: rtl/nn_layer_ctrl.sv
// rtl/nn_layer_ctrl.sv - sequencer for one fully-connected layer (memory walk, ALU op, aggregator strobes)
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start                : job request, looked at only in IDLE
//   cfg_n_in, cfg_n_out  : inputs per neuron / neurons in layer, latched on start
//   busy                 : high in every state except IDLE
//   done                 : one-cycle pulse at the end of a job
//   mem_rd_en            : read strobe to input and weight memories
//   in_addr              : input activation index i
//   w_addr               : weight address j*n_in+i (running counter)
//   alu_op               : OP_MUL while accumulating, else OP_NOP
//   agg_clr, agg_en      : aggregator clear / accumulate
//   out_we, out_addr     : output memory write strobe and neuron index j
module nn_layer_ctrl
  import nn_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int WADDR_W = 16,
  parameter int OP_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   cfg_n_in,
  input  logic [CNT_W-1:0]   cfg_n_out,
  output logic               busy,
  output logic               done,
  output logic               mem_rd_en,
  output logic [CNT_W-1:0]   in_addr,
  output logic [WADDR_W-1:0] w_addr,
  output logic [OP_W-1:0]    alu_op,
  output logic               agg_clr,
  output logic               agg_en,
  output logic               out_we,
  output logic [CNT_W-1:0]   out_addr
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nx;
  strobe_t            strb;

  logic [CNT_W-1:0]   n_in_q;
  logic [CNT_W-1:0]   n_out_q;
  logic [WADDR_W-1:0] w_addr_q;
  logic               acc_q;

  logic [CNT_W-1:0]   i_cnt;
  logic [CNT_W-1:0]   j_cnt;
  logic               i_last;
  logic               j_last;

  logic               job_ok;
  logic               accept;
  logic               j_inc;

  // An empty job (either count zero) still completes through DONE so the
  // caller always sees exactly one done pulse per start.
  assign job_ok = (cfg_n_in != '0) && (cfg_n_out != '0);
  assign accept = (state == ST_IDLE) && start && job_ok;
  assign strb   = decode_strobes(state);
  assign j_inc  = (state == ST_WRITE) && !j_last;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = job_ok ? ST_CLEAR : ST_DONE;
        end
      end
      ST_CLEAR: state_nx = ST_READ;
      ST_READ: begin
        if (i_last) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: state_nx = ST_WRITE;
      ST_WRITE: state_nx = j_last ? ST_DONE : ST_CLEAR;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Counts are frozen for the whole job; later cfg_* activity is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_in_q  <= '0;
      n_out_q <= '0;
    end else if (accept) begin
      n_in_q  <= cfg_n_in;
      n_out_q <= cfg_n_out;
    end
  end

  // Weight address runs straight through all neurons: row-major weights make
  // j*n_in+i simply the number of reads issued so far in this job.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_addr_q <= '0;
    end else if (accept) begin
      w_addr_q <= '0;
    end else if (strb.rd) begin
      w_addr_q <= w_addr_q + WADDR_W'(1);
    end
  end

  // Memory read data arrives one cycle after the strobe, so accumulation is
  // the read strobe delayed by one register. The last read's accumulate
  // therefore lands in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= strb.rd;
    end
  end

  nn_loop_cnt #(
    .W(CNT_W)
  ) u_i_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (strb.clr),
    .inc  (strb.rd),
    .limit(n_in_q),
    .cnt  (i_cnt),
    .last (i_last)
  );

  nn_loop_cnt #(
    .W(CNT_W)
  ) u_j_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .inc  (j_inc),
    .limit(n_out_q),
    .cnt  (j_cnt),
    .last (j_last)
  );

  assign busy      = strb.busy;
  assign done      = strb.dn;
  assign mem_rd_en = strb.rd;
  assign agg_clr   = strb.clr;
  assign out_we    = strb.we;
  assign agg_en    = acc_q;
  assign alu_op    = acc_q ? OP_W'(OP_MUL) : OP_W'(OP_NOP);
  assign in_addr   = i_cnt;
  assign out_addr  = j_cnt;
  assign w_addr    = w_addr_q;

endmodule

// File: tb/tb_nn_layer_ctrl.sv
// tb/tb_nn_layer_ctrl.sv - scoreboard bench for nn_layer_ctrl
module tb_nn_layer_ctrl;
  import nn_pkg::*;

  localparam int CNT_W   = 8;
  localparam int WADDR_W = 16;
  localparam int OP_W    = 2;
  localparam int NOCUT   = 1000000;

  localparam int K_RD  = 0;
  localparam int K_EN  = 1;
  localparam int K_CLR = 2;
  localparam int K_WE  = 3;
  localparam int K_DN  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [CNT_W-1:0]   cfg_n_in;
  logic [CNT_W-1:0]   cfg_n_out;
  logic               busy;
  logic               done;
  logic               mem_rd_en;
  logic [CNT_W-1:0]   in_addr;
  logic [WADDR_W-1:0] w_addr;
  logic [OP_W-1:0]    alu_op;
  logic               agg_clr;
  logic               agg_en;
  logic               out_we;
  logic [CNT_W-1:0]   out_addr;

  nn_layer_ctrl #(
    .CNT_W  (CNT_W),
    .WADDR_W(WADDR_W),
    .OP_W   (OP_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_n_in (cfg_n_in),
    .cfg_n_out(cfg_n_out),
    .busy     (busy),
    .done     (done),
    .mem_rd_en(mem_rd_en),
    .in_addr  (in_addr),
    .w_addr   (w_addr),
    .alu_op   (alu_op),
    .agg_clr  (agg_clr),
    .agg_en   (agg_en),
    .out_we   (out_we),
    .out_addr (out_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int a;
    int b;
  } ev_t;

  ev_t q_rd[$];
  ev_t q_en[$];
  ev_t q_clr[$];
  ev_t q_we[$];
  ev_t q_dn[$];

  int n_vec     = 0;
  int n_err     = 0;
  int last_done = -1;
  int last_rd_w = -1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int a, input int b);
    ev_t e;
    e.c = c;
    e.a = a;
    e.b = b;
    case (kind)
      K_RD:    q_rd.push_back(e);
      K_EN:    q_en.push_back(e);
      K_CLR:   q_clr.push_back(e);
      K_WE:    q_we.push_back(e);
      default: q_dn.push_back(e);
    endcase
  endtask

  // Expected schedule for a job whose start is sampled in cycle c0; events at
  // or after c0+cut are dropped (used when reset aborts a job).
  task automatic gen_job(input int c0, input int ni, input int no, input int cut);
    int base;
    if (ni == 0 || no == 0) begin
      if (1 < cut) push(K_DN, c0 + 1, 0, 0);
      return;
    end
    for (int j = 0; j < no; j++) begin
      base = 1 + j * (ni + 3);
      if (base < cut) push(K_CLR, c0 + base, 0, 0);
      for (int i = 0; i < ni; i++) begin
        if (base + 1 + i < cut) push(K_RD, c0 + base + 1 + i, i, j * ni + i);
        if (base + 2 + i < cut) push(K_EN, c0 + base + 2 + i, 0, 0);
      end
      if (base + ni + 2 < cut) push(K_WE, c0 + base + ni + 2, j, 0);
    end
    if (no * (ni + 3) + 1 < cut) push(K_DN, c0 + no * (ni + 3) + 1, 0, 0);
  endtask

  task automatic drive_start(input int ni, input int no);
    cfg_n_in  = CNT_W'(ni);
    cfg_n_out = CNT_W'(no);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    cfg_n_in  = CNT_W'($urandom);
    cfg_n_out = CNT_W'($urandom);
  endtask

  task automatic start_job(input int ni, input int no, input int cut, output int c0);
    c0 = cyc;
    gen_job(c0, ni, no, cut);
    drive_start(ni, no);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_mem_rd_en"}, mem_rd_en, 0);
    check({tag, "_agg_clr"},   agg_clr,   0);
    check({tag, "_agg_en"},    agg_en,    0);
    check({tag, "_out_we"},    out_we,    0);
    check({tag, "_alu_op"},    alu_op,    OP_NOP);
    check({tag, "_in_addr"},   in_addr,   0);
    check({tag, "_w_addr"},    w_addr,    0);
    check({tag, "_out_addr"},  out_addr,  0);
  endtask

  // Monitor: every strobe the DUT presents consumes the next expected event.
  always @(negedge clk) begin
    ev_t e;
    if (rst === 1'b0) check("alu_op_vs_agg_en", alu_op, agg_en ? OP_MUL : OP_NOP);
    if (mem_rd_en === 1'b1) begin
      if (q_rd.size() == 0) check("rd_unexpected", 1, 0);
      else begin
        e = q_rd.pop_front();
        check("rd_cycle", cyc, e.c);
        check("in_addr", in_addr, e.a);
        check("w_addr", w_addr, e.b);
        last_rd_w = int'(w_addr);
      end
    end
    if (agg_en === 1'b1) begin
      if (q_en.size() == 0) check("en_unexpected", 1, 0);
      else begin
        e = q_en.pop_front();
        check("en_cycle", cyc, e.c);
      end
    end
    if (agg_clr === 1'b1) begin
      if (q_clr.size() == 0) check("clr_unexpected", 1, 0);
      else begin
        e = q_clr.pop_front();
        check("clr_cycle", cyc, e.c);
      end
    end
    if (out_we === 1'b1) begin
      if (q_we.size() == 0) check("we_unexpected", 1, 0);
      else begin
        e = q_we.pop_front();
        check("we_cycle", cyc, e.c);
        check("out_addr", out_addr, e.a);
      end
    end
    if (done === 1'b1) begin
      last_done = cyc;
      if (q_dn.size() == 0) check("done_unexpected", 1, 0);
      else begin
        e = q_dn.pop_front();
        check("done_cycle", cyc, e.c);
        check("busy_in_done", busy, 1);
      end
    end
  end

  int rd_rel[6] = '{2, 3, 4, 8, 9, 10};
  int rd_i[6]   = '{0, 1, 2, 0, 1, 2};
  int en_rel[6] = '{3, 4, 5, 9, 10, 11};

  initial begin
    int c0;
    int c1;
    rst       = 1'b1;
    start     = 1'b0;
    cfg_n_in  = '0;
    cfg_n_out = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // n_in=3, n_out=2 from the hand-written schedule
    c0 = cyc;
    for (int k = 0; k < 6; k++) push(K_RD, c0 + rd_rel[k], rd_i[k], k);
    for (int k = 0; k < 6; k++) push(K_EN, c0 + en_rel[k], 0, 0);
    push(K_CLR, c0 + 1, 0, 0);
    push(K_CLR, c0 + 7, 0, 0);
    push(K_WE, c0 + 6, 0, 0);
    push(K_WE, c0 + 12, 1, 0);
    push(K_DN, c0 + 13, 0, 0);
    drive_start(3, 2);
    wait_until(c0 + 16);
    check("t1_done_rel", last_done - c0, 13);

    // n_in=1, n_out=1 hand schedule
    c0 = cyc;
    push(K_CLR, c0 + 1, 0, 0);
    push(K_RD, c0 + 2, 0, 0);
    push(K_EN, c0 + 3, 0, 0);
    push(K_WE, c0 + 4, 0, 0);
    push(K_DN, c0 + 5, 0, 0);
    drive_start(1, 1);
    wait_until(c0 + 8);
    check("t2_done_rel", last_done - c0, 5);

    // empty jobs
    start_job(0, 5, NOCUT, c0);
    wait_until(c0 + 4);
    check("t3a_done_rel", last_done - c0, 1);
    start_job(4, 0, NOCUT, c0);
    wait_until(c0 + 4);
    check("t3b_done_rel", last_done - c0, 1);

    // start during READ and in DONE ignored; start one cycle later accepted
    start_job(2, 1, NOCUT, c0);
    wait_until(c0 + 2);
    check("t4_in_read", mem_rd_en, 1);
    cfg_n_in  = 8'd3;
    cfg_n_out = 8'd3;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(c0 + 6);
    check("t4_done_pulse", done, 1);
    cfg_n_in  = 8'd2;
    cfg_n_out = 8'd1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_idle_busy", busy, 0);
    start_job(1, 1, NOCUT, c1);
    check("t4_restart_clr", agg_clr, 1);
    wait_until(c1 + 8);
    check("t4_restart_done_rel", last_done - c1, 5);

    // reset during READ of neuron 1 (n_in=4, n_out=3)
    start_job(4, 3, 11, c0);
    wait_until(c0 + 10);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
    @(negedge clk);
    start_job(4, 3, NOCUT, c1);
    wait_until(c1 + 25);
    check("t5_done_rel", last_done - c1, 22);

    // largest legal job
    start_job(255, 255, NOCUT, c0);
    wait_until(c0 + 65793);
    check("t6_done_rel", last_done - c0, 65791);
    check("t6_last_w_addr", last_rd_w, 65024);

    repeat (2) @(negedge clk);
    check("left_rd", q_rd.size(), 0);
    check("left_en", q_en.size(), 0);
    check("left_clr", q_clr.size(), 0);
    check("left_we", q_we.size(), 0);
    check("left_done", q_dn.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
